// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with accumulator, iterative mul/div and sticky error state
module alu_seq #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3:0]     op,
    input  logic           src_a,
    input  logic           src_b,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           err,
    output logic [2*W-1:0] acc,
    output logic [1:0]     state
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_EXEC  = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;
    localparam logic [1:0] S_ERROR = 2'b11;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_NAND = 4'd8;
    localparam logic [3:0] OP_NOR  = 4'd9;
    localparam logic [3:0] OP_XNOR = 4'd10;
    localparam logic [3:0] OP_SHL  = 4'd11;
    localparam logic [3:0] OP_SHR  = 4'd12;
    localparam logic [3:0] OP_NOP  = 4'd13;
    localparam logic [3:0] OP_RSV  = 4'd14;
    localparam logic [3:0] OP_CLR  = 4'd15;

    localparam int            CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [W-1:0]  SH_LIM   = W'(2 * W);

    logic [1:0]     state_q;
    logic [2*W-1:0] result_q;
    logic           err_q;
    logic [2*W-1:0] acc_q;

    // Iterative datapath: p/m are product and shifted multiplicand, q is multiplier or
    // dividend/quotient, r is the partial remainder.
    logic [2*W-1:0] p_q, m_q;
    logic [W-1:0]   q_q, b_q, r_q;
    logic           is_div_q;
    logic [CW-1:0]  cnt_q;

    logic [W-1:0]   a_sel, b_sel;
    logic [W:0]     sum;
    logic [2*W-1:0] sc_res;
    logic           sc_err;
    logic           go_exec;

    logic [2*W-1:0] p_nx, m_nx, x_res;
    logic [W:0]     r_sh;
    logic           div_ge;
    logic [W-1:0]   r_nx, q_nx;

    function automatic logic [2*W-1:0] zext(input logic [W-1:0] x);
        return {{W{1'b0}}, x};
    endfunction

    assign a_sel   = src_a ? acc_q[W-1:0] : in_a;
    assign b_sel   = src_b ? acc_q[W-1:0] : in_b;
    assign sum     = {1'b0, a_sel} + {1'b0, b_sel};
    assign go_exec = (op == OP_MUL) || ((op == OP_DIV) && (b_sel != '0));

    always_comb begin
        sc_res = '0;
        sc_err = 1'b0;
        case (op)
            OP_ADD:  sc_res = {{(W-1){1'b0}}, sum};
            OP_SUB:  if (b_sel > a_sel) sc_err = 1'b1;
                     else sc_res = zext(a_sel - b_sel);
            OP_MUL:  sc_res = '0;
            OP_DIV:  sc_err = (b_sel == '0);
            OP_AND:  sc_res = zext(a_sel & b_sel);
            OP_OR:   sc_res = zext(a_sel | b_sel);
            OP_XOR:  sc_res = zext(a_sel ^ b_sel);
            OP_NOT:  sc_res = zext(~b_sel);
            OP_NAND: sc_res = zext(~(a_sel & b_sel));
            OP_NOR:  sc_res = zext(~(a_sel | b_sel));
            OP_XNOR: sc_res = zext(~(a_sel ^ b_sel));
            OP_SHL:  sc_res = (a_sel >= SH_LIM) ? '0 : (zext(b_sel) << a_sel);
            OP_SHR:  sc_res = (a_sel >= SH_LIM) ? '0 : (zext(b_sel) >> a_sel);
            OP_NOP:  sc_res = acc_q;
            OP_RSV:  sc_err = 1'b1;
            OP_CLR:  sc_res = '0;
            default: sc_res = '0;
        endcase
        if (sc_err) sc_res = '0;
    end

    // One shift-add or one restoring-division step per EXEC cycle.
    assign p_nx   = q_q[0] ? (p_q + m_q) : p_q;
    assign m_nx   = m_q << 1;
    assign r_sh   = {r_q, q_q[W-1]};
    assign div_ge = (r_sh >= {1'b0, b_q});
    assign r_nx   = div_ge ? W'(r_sh - {1'b0, b_q}) : r_sh[W-1:0];
    assign q_nx   = is_div_q ? {q_q[W-2:0], div_ge} : {1'b0, q_q[W-1:1]};
    assign x_res  = is_div_q ? {r_nx, q_nx} : p_nx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (go_exec) begin
                            state_q  <= S_EXEC;
                            cnt_q    <= '0;
                            is_div_q <= (op == OP_DIV);
                            p_q      <= '0;
                            m_q      <= zext(a_sel);
                            q_q      <= (op == OP_DIV) ? a_sel : b_sel;
                            r_q      <= '0;
                            b_q      <= b_sel;
                        end else begin
                            state_q  <= S_DONE;
                            result_q <= sc_res;
                            err_q    <= sc_err;
                            if (!sc_err) acc_q <= sc_res;
                        end
                    end
                end
                S_EXEC: begin
                    p_q   <= p_nx;
                    m_q   <= m_nx;
                    q_q   <= q_nx;
                    r_q   <= r_nx;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q  <= S_DONE;
                        result_q <= x_res;
                        err_q    <= 1'b0;
                        acc_q    <= x_res;
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= err_q ? S_ERROR : S_IDLE;
                end
                default: begin
                    // Sticky error: only clear recovers; anything else reports err again.
                    if (in_valid) begin
                        state_q  <= S_DONE;
                        result_q <= '0;
                        err_q    <= (op != OP_CLR);
                        if (op == OP_CLR) acc_q <= '0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign err       = err_q;
    assign acc       = acc_q;
    assign state     = state_q;

endmodule
